// File: rtl/m1_ifetch_wra.sv
// AHB master wrapper for the instruction-fetch port (M1): one single-word
// NONSEQ read per core fetch, with the core stalled until the word returns.
module m1_ifetch_wra #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter logic [DATA_W-1:0]   NOP_INST = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_flush,
  output logic              cpu_stall,
  output logic              inst_valid,
  output logic [DATA_W-1:0] cpu_inst,
  output logic              fetch_err,
  output logic              HBUSREQ_M1,
  input  logic              HGRANT_M1,
  output logic [ADDR_W-1:0] HADDR_M1,
  output logic [1:0]        HTRANS_M1,
  output logic [2:0]        HSIZE_M1,
  output logic              HWRITE_M1,
  output logic [DATA_W-1:0] HWDATA_M1,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);

  localparam int unsigned WADDR_W    = ADDR_W - 2;
  localparam logic [1:0]  TRANS_IDLE = 2'b00;
  localparam logic [1:0]  TRANS_NSEQ = 2'b10;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [2:0]  SIZE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_MISAL = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WADDR_W-1:0]  r_addr_q;
  logic                r_flush_q;
  logic                r_inst_valid;
  logic                r_fetch_err;
  logic [DATA_W-1:0]   r_cpu_inst;

  logic                w_addr_load;
  logic                w_flush_d;
  logic                w_iv_set;
  logic                w_err_set;
  logic                w_inst_load;
  logic [DATA_W-1:0]   w_inst_val;
  logic [ADDR_W-1:0]   w_haddr;

  assign w_haddr    = {r_addr_q, 2'b00};
  assign HSIZE_M1   = SIZE_WORD;
  assign HWRITE_M1  = 1'b0;
  assign HWDATA_M1  = '0;
  assign inst_valid = r_inst_valid;
  assign fetch_err  = r_fetch_err;
  assign cpu_inst   = r_cpu_inst;

  // State register and core-facing result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr_q     <= '0;
      r_flush_q    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_cpu_inst   <= NOP_INST;
    end else begin
      r_state      <= w_next;
      r_flush_q    <= w_flush_d;
      r_inst_valid <= w_iv_set;
      r_fetch_err  <= w_err_set;
      if (w_addr_load) r_addr_q   <= cpu_addr[ADDR_W-1:2];
      if (w_inst_load) r_cpu_inst <= w_inst_val;
    end
  end

  // Next state, bus-phase outputs and result updates
  always_comb begin
    w_next      = r_state;
    cpu_stall   = 1'b0;
    HBUSREQ_M1  = 1'b0;
    HTRANS_M1   = TRANS_IDLE;
    HADDR_M1    = '0;
    w_addr_load = 1'b0;
    w_flush_d   = r_flush_q;
    w_iv_set    = 1'b0;
    w_err_set   = 1'b0;
    w_inst_load = 1'b0;
    w_inst_val  = NOP_INST;
    case (r_state)
      ST_IDLE: begin
        w_flush_d = 1'b0;
        // The inst_valid cycle itself never accepts; the core re-requests next cycle.
        if (cpu_req && !cpu_flush && !r_inst_valid) begin
          cpu_stall   = 1'b1;
          w_addr_load = 1'b1;
          if (cpu_addr[1:0] != 2'b00) begin
            w_next      = ST_MISAL;
            w_iv_set    = 1'b1;
            w_err_set   = 1'b1;
            w_inst_load = 1'b1;
          end else begin
            w_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cpu_stall  = 1'b1;
        HBUSREQ_M1 = 1'b1;
        if (cpu_flush)                  w_next = ST_IDLE;
        else if (HGRANT_M1 && HREADY)   w_next = ST_ADDR;
      end
      ST_ADDR: begin
        cpu_stall  = 1'b1;
        HBUSREQ_M1 = 1'b1;
        HTRANS_M1  = TRANS_NSEQ;
        HADDR_M1   = w_haddr;
        if (cpu_flush) w_flush_d = 1'b1;
        if (HREADY)    w_next    = ST_DATA;
      end
      ST_DATA: begin
        cpu_stall = 1'b1;
        HADDR_M1  = w_haddr;
        if (cpu_flush) w_flush_d = 1'b1;
        if (HREADY) begin
          w_next = ST_IDLE;
          // A flushed transfer still completes on the bus but is not delivered.
          if (!(r_flush_q || cpu_flush)) begin
            w_iv_set    = 1'b1;
            w_inst_load = 1'b1;
            if (HRESP == RESP_OKAY) w_inst_val = HRDATA;
            else                    w_err_set  = 1'b1;
          end
        end
      end
      ST_MISAL: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_m1_ifetch_wra.sv
// Directed bench for m1_ifetch_wra: AHB slave/arbiter model, transaction-level
// scoreboard checked every cycle, plus hand-computed latency/value checks.
module tb_m1_ifetch_wra;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_flush = 1'b0;
  logic        cpu_stall, inst_valid, fetch_err;
  logic [31:0] cpu_inst;
  logic        HBUSREQ_M1;
  logic        HGRANT_M1 = 1'b0;
  logic [31:0] HADDR_M1;
  logic [1:0]  HTRANS_M1;
  logic [2:0]  HSIZE_M1;
  logic        HWRITE_M1;
  logic [31:0] HWDATA_M1;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = 2'b00;

  always #5 clk = ~clk;

  m1_ifetch_wra #(.ADDR_W(32), .DATA_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_flush(cpu_flush), .cpu_stall(cpu_stall), .inst_valid(inst_valid),
    .cpu_inst(cpu_inst), .fetch_err(fetch_err), .HBUSREQ_M1(HBUSREQ_M1),
    .HGRANT_M1(HGRANT_M1), .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1),
    .HSIZE_M1(HSIZE_M1), .HWRITE_M1(HWRITE_M1), .HWDATA_M1(HWDATA_M1),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h00A0_0093;
      32'h44:  return 32'h0010_0113;
      32'h48:  return 32'h0020_0193;
      32'h4C:  return 32'h0030_0213;
      32'h50:  return 32'h0040_0293;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // What the core must see for a delivered fetch: {fetch_err, cpu_inst}
  function automatic logic [32:0] model_result(input logic [31:0] a, input logic [1:0] resp);
    if (a[1:0] != 2'b00) return {1'b1, NOP};
    if (resp != 2'b00)   return {1'b1, NOP};
    return {1'b0, mem_rd({a[31:2], 2'b00})};
  endfunction

  logic [32:0] exp_q[$];
  logic [31:0] bus_q[$];
  logic [31:0] model_inst = NOP;

  // Slave / arbiter model configuration
  int         dp_left = -1;
  logic [31:0] dp_addr = '0;
  int         hold_low = 0;
  int         gcnt = 0;
  int         gdly_cfg = 0;
  int         ws_cfg = 0;
  logic [1:0] resp_cfg = 2'b00;
  bit         park = 1'b0;
  bit         drop_grant = 1'b0;

  // Inputs for the upcoming rising edge are decided on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0; HGRANT_M1 = 1'b0;
      dp_left = -1; hold_low = 0; gcnt = 0;
    end else begin
      HRESP  = 2'b00;
      HRDATA = 32'hDEAD_BEEF;
      if (dp_left > 0) begin
        HREADY = 1'b0; dp_left--;
      end else if (dp_left == 0) begin
        HREADY = 1'b1; HRDATA = mem_rd(dp_addr); HRESP = resp_cfg; dp_left = -1;
      end else if (hold_low > 0 && HTRANS_M1 == 2'b10) begin
        HREADY = 1'b0; hold_low--;
      end else begin
        HREADY = 1'b1;
      end
      if (HTRANS_M1 == 2'b10 && HREADY) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: NONSEQ at %h, none expected", HADDR_M1);
        end else begin
          chk("bus_addr", HADDR_M1, bus_q.pop_front());
        end
        dp_left = ws_cfg;
        dp_addr = HADDR_M1;
      end
      if (HBUSREQ_M1) begin
        if (drop_grant && HTRANS_M1 == 2'b10) HGRANT_M1 = 1'b0;
        else if (park || gcnt >= gdly_cfg)    HGRANT_M1 = 1'b1;
        else begin HGRANT_M1 = 1'b0; gcnt++; end
      end else begin
        HGRANT_M1 = park;
        gcnt = 0;
      end
    end
  end

  // Per-cycle scoreboard and protocol checks
  logic        prev_nonseq = 1'b0;
  logic        prev_hready = 1'b1;
  logic [31:0] prev_addr = '0;
  logic [32:0] e;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      model_inst  = NOP;
      exp_q.delete();
      prev_nonseq = 1'b0;
    end else begin
      chk("hsize", 32'(HSIZE_M1), 32'd2);
      chk("hwrite", 32'(HWRITE_M1), 32'd0);
      chk("hwdata", HWDATA_M1, 32'd0);
      if (inst_valid) begin
        chk("stall_in_valid", 32'(cpu_stall), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_valid: inst_valid=1 cpu_inst=%h, none expected", cpu_inst);
        end else begin
          e = exp_q.pop_front();
          chk("inst", cpu_inst, e[31:0]);
          chk("err", 32'(fetch_err), 32'(e[32]));
          model_inst = e[31:0];
        end
      end else begin
        chk("err_no_valid", 32'(fetch_err), 32'd0);
        chk("inst_hold", cpu_inst, model_inst);
      end
      if (HTRANS_M1 == 2'b10) chk("busreq_in_addr", 32'(HBUSREQ_M1), 32'd1);
      if (prev_nonseq && !prev_hready) begin
        chk("addr_hold_trans", 32'(HTRANS_M1), 32'd2);
        chk("addr_hold_addr", HADDR_M1, prev_addr);
      end
      prev_nonseq = (HTRANS_M1 == 2'b10);
      prev_hready = HREADY;
      prev_addr   = HADDR_M1;
    end
  end

  // One fetch; lat = cycle of inst_valid after acceptance (0 if it ended without one)
  task automatic fetch(input logic [31:0] a, input int ws, input logic [1:0] resp,
                       input int gdly, input int flush_at, input bit expect_bus,
                       output int stall_cyc, output int lat, output int req_cyc,
                       output int addr_cyc);
    ws_cfg = ws; resp_cfg = resp; gdly_cfg = gdly;
    @(negedge clk);
    if (expect_bus) bus_q.push_back({a[31:2], 2'b00});
    if (flush_at < 0) exp_q.push_back(model_result(a, resp));
    cpu_req = 1'b1; cpu_addr = a; cpu_flush = 1'b0;
    #1 chk("stall_accept", 32'(cpu_stall), 32'd1);
    stall_cyc = 1; lat = -1; req_cyc = 0; addr_cyc = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      cpu_req   = 1'b0;
      cpu_flush = (k == flush_at);
      #1;
      if (inst_valid) begin lat = k; break; end
      if (!cpu_stall) begin lat = 0; break; end
      stall_cyc++;
      if (HTRANS_M1 == 2'b10) addr_cyc++;
      else if (HBUSREQ_M1)    req_cyc++;
    end
    cpu_flush = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: addr %h got no completion within 80 cycles, required one", a);
    end
  endtask

  int s, l, r, ad, cnt;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_inst", cpu_inst, NOP);
    chk("rst_hsize", 32'(HSIZE_M1), 32'd2);
    chk("rst_htrans", 32'(HTRANS_M1), 32'd0);
    chk("rst_busreq", 32'(HBUSREQ_M1), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_haddr", HADDR_M1, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Aligned fetch, immediate grant, 2 data wait states
    fetch(32'h40, 2, 2'b00, 0, -1, 1'b1, s, l, r, ad);
    chk("t1_stall_cycles", 32'(s), 32'd6);
    chk("t1_latency", 32'(l), 32'd6);
    chk("t1_inst", cpu_inst, 32'h00A0_0093);

    // Zero-wait, back-to-back with the previous fetch
    fetch(32'h44, 0, 2'b00, 0, -1, 1'b1, s, l, r, ad);
    chk("t2_latency", 32'(l), 32'd4);
    chk("t2_stall_cycles", 32'(s), 32'd4);
    chk("t2_inst", cpu_inst, 32'h0010_0113);

    // Flush during the data phase: bus completes, nothing delivered
    fetch(32'h50, 2, 2'b00, 0, 4, 1'b1, s, l, r, ad);
    chk("t3_no_valid", 32'(l), 32'd0);
    chk("t3_stall_cycles", 32'(s), 32'd6);
    @(negedge clk); #1;
    chk("t3_inst_kept", cpu_inst, 32'h0010_0113);
    fetch(32'h44, 0, 2'b00, 0, -1, 1'b1, s, l, r, ad);
    chk("t3_refetch_latency", 32'(l), 32'd4);

    // Grant delayed 5 cycles, HREADY low 3 cycles in ADDR, grant dropped in ADDR
    hold_low = 3; drop_grant = 1'b1;
    fetch(32'h48, 0, 2'b00, 5, -1, 1'b1, s, l, r, ad);
    drop_grant = 1'b0;
    chk("t4_req_cycles", 32'(r), 32'd6);
    chk("t4_addr_cycles", 32'(ad), 32'd4);
    chk("t4_latency", 32'(l), 32'd12);
    chk("t4_inst", cpu_inst, 32'h0020_0193);

    // Error response
    fetch(32'h4C, 1, 2'b01, 0, -1, 1'b1, s, l, r, ad);
    chk("t5_latency", 32'(l), 32'd5);
    chk("t5_inst", cpu_inst, NOP);
    chk("t5_err", 32'(fetch_err), 32'd1);
    @(negedge clk); #1;
    chk("t5_valid_pulse", 32'(inst_valid), 32'd0);
    chk("t5_err_pulse", 32'(fetch_err), 32'd0);

    // Misaligned: no bus traffic, result one cycle after acceptance
    fetch(32'h42, 0, 2'b00, 0, -1, 1'b0, s, l, r, ad);
    chk("t6_latency", 32'(l), 32'd1);
    chk("t6_stall_cycles", 32'(s), 32'd1);
    chk("t6_inst", cpu_inst, NOP);
    chk("t6_err", 32'(fetch_err), 32'd1);

    // Flush together with request in IDLE: nothing accepted
    @(negedge clk);
    cpu_req = 1'b1; cpu_flush = 1'b1; cpu_addr = 32'h40;
    #1 chk("t7_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    cpu_req = 1'b0; cpu_flush = 1'b0;
    #1;
    chk("t7_busreq", 32'(HBUSREQ_M1), 32'd0);
    chk("t7_stall_after", 32'(cpu_stall), 32'd0);

    // Flush while waiting for grant
    fetch(32'h40, 0, 2'b00, 3, 1, 1'b0, s, l, r, ad);
    chk("t8_no_valid", 32'(l), 32'd0);
    chk("t8_stall_cycles", 32'(s), 32'd2);

    // Parked grant still costs one REQ cycle
    park = 1'b1;
    fetch(32'h44, 0, 2'b00, 0, -1, 1'b1, s, l, r, ad);
    park = 1'b0;
    chk("t9_latency", 32'(l), 32'd4);
    chk("t9_req_cycles", 32'(r), 32'd1);

    // Reset during the data phase
    ws_cfg = 4; resp_cfg = 2'b00; gdly_cfg = 0;
    @(negedge clk);
    bus_q.push_back(32'h48);
    exp_q.push_back(model_result(32'h48, 2'b00));
    cpu_req = 1'b1; cpu_addr = 32'h48;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("t10_in_data_haddr", HADDR_M1, 32'h48);
    #2 rst = 1'b0;
    #1;
    chk("t10_htrans", 32'(HTRANS_M1), 32'd0);
    chk("t10_busreq", 32'(HBUSREQ_M1), 32'd0);
    chk("t10_haddr", HADDR_M1, 32'd0);
    chk("t10_stall", 32'(cpu_stall), 32'd0);
    chk("t10_valid", 32'(inst_valid), 32'd0);
    chk("t10_inst", cpu_inst, NOP);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (inst_valid) cnt++;
    end
    chk("t10_no_spurious", 32'(cnt), 32'd0);
    chk("t10_idle_busreq", 32'(HBUSREQ_M1), 32'd0);

    fetch(32'h40, 0, 2'b00, 0, -1, 1'b1, s, l, r, ad);
    chk("t11_latency", 32'(l), 32'd4);
    chk("t11_inst", cpu_inst, 32'h00A0_0093);

    repeat (3) @(negedge clk);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m1_ifetch_wra.md
Name: m1_ifetch_wra

Overview:
- AHB master wrapper for the CPU instruction-fetch port (bus master M1, HMASTER code 4'b0010).
- Turns single-word fetch requests from the core into AHB single NONSEQ read transfers and returns the fetched instruction to the core.
- Sits directly upstream of the instruction-memory slave wrapper (S1) through the AHB bus/arbiter.
- Stalls the core for the whole duration of each fetch.

Parameters:
- ADDR_W, 32, address width (AHB_DATA_BITS).
- DATA_W, 32, data/instruction width.
- NOP_INST, 32'h0000_0013, instruction returned on error or misalignment.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- cpu_req  in  1  fetch request, level; sampled only in IDLE
- cpu_addr  in  ADDR_W  fetch address (PC)
- cpu_flush  in  1  discard the outstanding fetch
- cpu_stall  out  1  core must hold the PC
- inst_valid  out  1  one-cycle pulse, cpu_inst valid
- cpu_inst  out  DATA_W  fetched instruction, held until the next inst_valid
- fetch_err  out  1  one-cycle pulse with inst_valid on bus error or misalignment
- HBUSREQ_M1  out  1  bus request to the arbiter
- HGRANT_M1  in  1  grant from the arbiter
- HADDR_M1  out  ADDR_W  transfer address
- HTRANS_M1  out  2  IDLE=2'b00, NONSEQ=2'b10
- HSIZE_M1  out  3  fixed 3'b010 (word)
- HWRITE_M1  out  1  fixed 0
- HWDATA_M1  out  DATA_W  fixed 0
- HRDATA  in  DATA_W  read data from the bus mux
- HREADY  in  1  transfer-complete from the bus mux
- HRESP  in  2  2'b00 OKAY; any other value = error

Behaviour:

Reset (rst low, async):
- FSM enters IDLE; all outputs 0, except cpu_inst = NOP_INST and HSIZE_M1 = 3'b010.
- Reset mid-transfer abandons the transfer immediately: HTRANS_M1 = IDLE, HBUSREQ_M1 = 0. No inst_valid is produced for the abandoned fetch.

FSM states: IDLE, REQ, ADDR, DATA, MISAL.

- IDLE:
  - cpu_stall = 0.
  - On cpu_req=1 and cpu_flush=0: latch cpu_addr into addr_q and set cpu_stall combinationally the same cycle.
  - If cpu_addr[1:0] != 0, go to MISAL; otherwise go to REQ.
- REQ:
  - HBUSREQ_M1 = 1, HTRANS_M1 = IDLE.
  - Go to ADDR when HGRANT_M1=1 and HREADY=1.
  - On cpu_flush: return to IDLE, drop HBUSREQ_M1.
  - Always at least one cycle in REQ, even if the grant is already high.
- ADDR:
  - HBUSREQ_M1 = 1, HTRANS_M1 = NONSEQ, HADDR_M1 = {addr_q[ADDR_W-1:2], 2'b00}.
  - Address phase ends on the rising edge with HREADY=1; then go to DATA.
  - While HREADY=0, hold all address-phase signals stable.
- DATA:
  - HTRANS_M1 = IDLE, HBUSREQ_M1 = 0, HADDR_M1 holds addr_q.
  - Wait states (HREADY=0): unbounded, stay in DATA.
  - On HREADY=1: go to IDLE next cycle. If HRESP=OKAY, register cpu_inst = HRDATA; otherwise register NOP_INST with fetch_err=1. Pulse inst_valid for one cycle.
- MISAL:
  - No bus activity.
  - One cycle later: cpu_inst = NOP_INST, inst_valid = 1, fetch_err = 1; return to IDLE.

cpu_flush in ADDR or DATA:
- The AHB transfer must still complete (protocol), so a flush_q flag is set.
- On completion, cpu_inst is not updated and inst_valid/fetch_err stay 0.

cpu_stall:
- 1 from request acceptance through the cycle before inst_valid.
- 0 in the inst_valid cycle.
- A new cpu_req may be accepted in the cycle after inst_valid.

Latency and throughput:
- Latency with immediate grant and zero slave wait states: req accepted cycle 0, REQ 1, ADDR 2, DATA 3, inst_valid cycle 4.
- At most one outstanding fetch; no pipelining across transfers.

Simultaneous events:
- cpu_flush together with cpu_req in IDLE: flush wins, no request accepted.
- HGRANT_M1 deasserted while in ADDR with HREADY=0: the transfer is already owned and completes.

Test Plan:
- Aligned fetch 0x0000_0040, grant immediate, slave inserts 2 wait states in data phase, HRDATA=0x00A00093 -> one NONSEQ at 0x40; inst_valid exactly once with cpu_inst=0x00A00093; cpu_stall high 6 cycles.
- Grant delayed 5 cycles -> HBUSREQ_M1 high throughout; HTRANS_M1 stays IDLE until grant; HADDR/HTRANS stable while HREADY low in ADDR.
- HRESP=2'b01 on completion -> cpu_inst=0x00000013, fetch_err=1, inst_valid=1, all for one cycle.
- cpu_addr=0x0000_0042 -> no HTRANS NONSEQ; inst_valid and fetch_err one cycle after acceptance; cpu_inst=NOP_INST.
- Flush asserted in DATA state -> transfer completes on the bus; inst_valid stays 0; cpu_inst keeps its previous value; next request 0x44 fetches normally.
- Reset pulsed low during DATA -> all outputs back to reset values immediately; after release the FSM stays IDLE and there is no spurious inst_valid.
